// File: rtl/deja_glitch_pkg.sv
// ============================================================================
// Module   : deja_glitch_pkg
// Purpose  : Shared register offsets, CTRL bit indices and channel state enum.
// Revision : 1.0
// ============================================================================
`default_nettype none

package deja_glitch_pkg;

    localparam logic [1:0] REG_DELAY = 2'd0;
    localparam logic [1:0] REG_WIDTH = 2'd1;
    localparam logic [1:0] REG_STEP  = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_INV   = 1;
    localparam int CTRL_SWEEP = 2;
    localparam int CTRL_BUSY  = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DLY  = 2'd1,
        GLT  = 2'd2,
        HOLD = 2'd3
    } ch_state_t;

endpackage

`default_nettype wire

// File: rtl/deja_glitch_channel.sv
// ============================================================================
// Module   : deja_glitch_channel
// Purpose  : One glitch channel: live registers, run shadows, FSM, sweep adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module deja_glitch_channel
    import deja_glitch_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en,
    input  logic [1:0]       wr_reg,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             run,
    input  logic             rise,
    output logic [CNT_W-1:0] delay,
    output logic [CNT_W-1:0] width,
    output logic [CNT_W-1:0] step,
    output logic             en,
    output logic             inv,
    output logic             sweep,
    output logic             busy,
    output logic             power
);

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] sh_delay, sh_width;
    logic             sh_inv;
    logic             start;
    logic             sweep_inc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            delay <= '0;
            width <= '0;
            step  <= '0;
            en    <= 1'b0;
            inv   <= 1'b0;
            sweep <= 1'b0;
        end else begin
            // A bus write to DELAY takes priority over the sweep increment.
            if (wr_en && wr_reg == REG_DELAY) begin
                delay <= wr_data;
            end else if (sweep_inc) begin
                delay <= delay + step;
            end
            if (wr_en && wr_reg == REG_WIDTH) width <= wr_data;
            if (wr_en && wr_reg == REG_STEP)  step  <= wr_data;
            if (wr_en && wr_reg == REG_CTRL) begin
                en    <= wr_data[CTRL_EN];
                inv   <= wr_data[CTRL_INV];
                sweep <= wr_data[CTRL_SWEEP];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sh_delay <= '0;
            sh_width <= '0;
            sh_inv   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start) begin
                sh_delay <= delay;
                sh_width <= width;
                sh_inv   <= inv;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start     = 1'b0;
        sweep_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise && en) begin
                    start   = 1'b1;
                    state_d = DLY;
                    cnt_d   = '0;
                end
            end
            DLY: begin
                if (!run || !en) begin
                    state_d = IDLE;
                end else if (cnt_q == sh_delay) begin
                    if (sh_width == '0) begin
                        state_d   = HOLD;
                        sweep_inc = sweep;
                    end else begin
                        state_d = GLT;
                        cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GLT: begin
                if (!run || !en) begin
                    state_d = IDLE;
                end else if (cnt_q == sh_width) begin
                    state_d   = HOLD;
                    sweep_inc = sweep;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!run || !en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Idle polarity follows the live INV bit; during a run the shadow is used.
    assign power = (state_q == IDLE) ? ~inv : ((state_q != GLT) ^ sh_inv);
    assign busy  = (state_q != IDLE);

endmodule

`default_nettype wire

// File: rtl/deja_glitch_power_mc.sv
// ============================================================================
// Module   : deja_glitch_power_mc
// Purpose  : Multi-channel power glitcher: bus decode, read mux, ack, run edge.
//            Optional macro DEJA_GLITCH_SYNC_EN adds a 2-flop run_i synchroniser.
// Revision : 1.0
// ============================================================================
`default_nettype none

module deja_glitch_power_mc
    import deja_glitch_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 8,
    parameter int DAT_W    = 8,
    parameter int ADR_W    = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                stb_i,
    input  logic                we_i,
    input  logic [ADR_W-1:0]    adr_i,
    input  logic [DAT_W-1:0]    dat_i,
    output logic                ack_o,
    output logic [DAT_W-1:0]    dat_o,
    input  logic                run_i,
    output logic [CHANNELS-1:0] power_o
);

    localparam int CH_W = ADR_W - 2;

    logic [CH_W-1:0]  sel_ch;
    logic [1:0]       sel_reg;
    logic             accept;
    logic             wr_acc;
    logic [DAT_W-1:0] rd_data;
    logic             run;
    logic             run_q;
    logic             rise;

    logic [CNT_W-1:0]    ch_delay [CHANNELS];
    logic [CNT_W-1:0]    ch_width [CHANNELS];
    logic [CNT_W-1:0]    ch_step  [CHANNELS];
    logic [CHANNELS-1:0] ch_en, ch_inv, ch_sweep, ch_busy;

    assign sel_ch  = adr_i[ADR_W-1:2];
    assign sel_reg = adr_i[1:0];
    assign accept  = stb_i & ~ack_o;
    assign wr_acc  = accept & we_i;

`ifdef DEJA_GLITCH_SYNC_EN
    logic [1:0] run_sync;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) run_sync <= 2'b00;
        else         run_sync <= {run_sync[0], run_i};
    end

    assign run = run_sync[1];
`else
    assign run = run_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) run_q <= 1'b0;
        else         run_q <= run;
    end

    assign rise = run & ~run_q;

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
            logic wr_ch;
            assign wr_ch = wr_acc && (int'(sel_ch) == g);

            deja_glitch_channel #(
                .CNT_W (CNT_W)
            ) u_channel (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .wr_en   (wr_ch),
                .wr_reg  (sel_reg),
                .wr_data (dat_i),
                .run     (run),
                .rise    (rise),
                .delay   (ch_delay[g]),
                .width   (ch_width[g]),
                .step    (ch_step[g]),
                .en      (ch_en[g]),
                .inv     (ch_inv[g]),
                .sweep   (ch_sweep[g]),
                .busy    (ch_busy[g]),
                .power   (power_o[g])
            );
        end
    endgenerate

    // Unpopulated channel indices match no loop iteration and read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(sel_ch) == i) begin
                case (sel_reg)
                    REG_DELAY: rd_data = ch_delay[i];
                    REG_WIDTH: rd_data = ch_width[i];
                    REG_STEP:  rd_data = ch_step[i];
                    default: begin
                        rd_data[CTRL_EN]    = ch_en[i];
                        rd_data[CTRL_INV]   = ch_inv[i];
                        rd_data[CTRL_SWEEP] = ch_sweep[i];
                        rd_data[CTRL_BUSY]  = ch_busy[i];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_o <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_o <= accept;
            dat_o <= (accept && !we_i) ? rd_data : '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_deja_glitch_power_mc.sv
// ============================================================================
// Module   : tb_deja_glitch_power_mc
// Purpose  : Self-checking bench for deja_glitch_power_mc (default build).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_deja_glitch_power_mc;

    localparam int CHANNELS = 2;
    localparam int CNT_W    = 8;
    localparam int DAT_W    = 8;
    localparam int ADR_W    = 5;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic                stb   = 1'b0;
    logic                we    = 1'b0;
    logic                run   = 1'b0;
    logic [ADR_W-1:0]    adr   = '0;
    logic [DAT_W-1:0]    dat_w = '0;
    logic                ack;
    logic [DAT_W-1:0]    dat_r;
    logic [CHANNELS-1:0] power;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    deja_glitch_power_mc #(
        .CHANNELS (CHANNELS),
        .CNT_W    (CNT_W),
        .DAT_W    (DAT_W),
        .ADR_W    (ADR_W)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .stb_i   (stb),
        .we_i    (we),
        .adr_i   (adr),
        .dat_i   (dat_w),
        .ack_o   (ack),
        .dat_o   (dat_r),
        .run_i   (run),
        .power_o (power)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input int ch, input int r, input int data);
        @(negedge clk);
        stb = 1'b1; we = 1'b1; adr = ADR_W'(ch * 4 + r); dat_w = DAT_W'(data);
        @(negedge clk);
        stb = 1'b0; we = 1'b0;
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("FAIL wr_ack ch%0d r%0d: got %b want 1", ch, r, ack);
        end
    endtask

    task automatic bus_read(input int ch, input int r, input logic [7:0] want_in, input string name);
        int n;
        logic [7:0] want;
        @(negedge clk);
        stb = 1'b1; we = 1'b0; adr = ADR_W'(ch * 4 + r);
        exp_q.push_back(want_in);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack !== 1'b1 && n < 8);
        stb = 1'b0;
        want = exp_q.pop_front();
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("FAIL %s: no ack within %0d cycles", name, n);
        end else if (dat_r !== want) begin
            bad++;
            $display("FAIL %s ch%0d r%0d: got %h want %h", name, ch, r, dat_r, want);
        end
    endtask

    // Raises run for n_cyc+1 cycles; cut expected at cycles d+1..d+w after edge k.
    task automatic run_glitch(input int ch, input int d, input int w, input logic inv,
                              input logic oth_exp, input int n_cyc, input string name);
        int errs, first, oth;
        logic e;
        errs = 0; first = -1; oth = 1 - ch;
        @(negedge clk);
        run = 1'b1;
        for (int j = 0; j <= n_cyc; j++) begin
            @(negedge clk);
            e = ((j >= d + 1 && j <= d + w) ? 1'b0 : 1'b1) ^ inv;
            if (power[ch] !== e || power[oth] !== oth_exp) begin
                errs++;
                if (first < 0) first = j;
            end
        end
        run = 1'b0;
        @(negedge clk);
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s d=%0d w=%0d: %0d bad cycles, first at k+%0d, want 0", name, d, w, errs, first);
        end
        @(negedge clk);
        total++;
        if (power[ch] !== ~inv) begin
            bad++;
            $display("FAIL %s_idle: got %b want %b", name, power[ch], ~inv);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (power !== 2'b11 || ack !== 1'b0 || dat_r !== 8'h00) begin
            bad++;
            $display("FAIL reset_out: power=%b ack=%b dat=%h want 11/0/00", power, ack, dat_r);
        end
        rst_n = 1'b1;
        for (int c = 0; c < CHANNELS; c++)
            for (int r = 0; r < 4; r++)
                bus_read(c, r, 8'h00, "reset_reg");
    endtask

    task automatic test_single();
        bus_write(0, 0, 3);
        bus_write(0, 1, 2);
        bus_write(0, 3, 8'h01);
        run_glitch(0, 3, 2, 1'b0, 1'b1, 10, "single");
    endtask

    task automatic test_sweep();
        int d;
        bus_write(0, 2, 2);
        bus_write(0, 0, 250);
        bus_write(0, 3, 8'h05);
        for (int n = 0; n < 6; n++) begin
            d = (250 + 2 * n) % 256;
            run_glitch(0, d, 2, 1'b0, 1'b1, d + 5, "sweep_run");
            bus_read(0, 0, 8'((d + 2) % 256), "sweep_delay");
        end
    endtask

    task automatic test_abort();
        bus_write(0, 0, 10);
        bus_write(0, 1, 20);
        @(negedge clk);
        run = 1'b1;
        repeat (14) @(negedge clk);
        total++;
        if (power[0] !== 1'b0) begin
            bad++;
            $display("FAIL abort_in_glt: got %b want 0", power[0]);
        end
        run = 1'b0;
        @(negedge clk);
        total++;
        if (power[0] !== 1'b1) begin
            bad++;
            $display("FAIL abort_restore: got %b want 1", power[0]);
        end
        bus_read(0, 0, 8'd10, "abort_delay");
        bus_read(0, 3, 8'h05, "abort_ctrl");
    endtask

    task automatic test_inv();
        int errs;
        bus_write(0, 3, 8'h00);
        bus_write(1, 0, 2);
        bus_write(1, 1, 0);
        bus_write(1, 3, 8'h03);
        total++;
        if (power !== 2'b01) begin
            bad++;
            $display("FAIL inv_idle: got %b want 01", power);
        end
        @(negedge clk);
        run = 1'b1;
        errs = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (power !== 2'b01) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL inv_w0_run: %0d bad cycles want 0", errs);
        end
        bus_write(1, 0, 5);
        bus_write(1, 1, 1);
        total++;
        if (power !== 2'b01) begin
            bad++;
            $display("FAIL inv_midrun: got %b want 01", power);
        end
        bus_read(1, 3, 8'h83, "inv_busy");
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus_read(1, 3, 8'h03, "inv_idle_ctrl");
        run_glitch(1, 5, 1, 1'b1, 1'b1, 9, "inv_next");
    endtask

    task automatic test_out_of_range();
        bus_write(3, 0, 8'hAA);
        bus_write(3, 3, 8'h07);
        bus_read(3, 0, 8'h00, "oor_delay");
        bus_read(3, 3, 8'h00, "oor_ctrl");
        bus_read(1, 0, 8'd5, "oor_ch1_delay");
        bus_read(1, 3, 8'h03, "oor_ch1_ctrl");
        bus_read(0, 0, 8'd10, "oor_ch0_delay");
        total++;
        if (power !== 2'b01) begin
            bad++;
            $display("FAIL oor_power: got %b want 01", power);
        end
    endtask

    task automatic test_back_to_back();
        logic want_ack;
        logic [7:0] want;
        @(negedge clk);
        stb = 1'b1; we = 1'b0; adr = ADR_W'(1 * 4 + 0);
        for (int j = 0; j < 4; j++) begin
            want_ack = (j % 2 == 0);
            if (want_ack) exp_q.push_back(8'd5);
            @(negedge clk);
            total++;
            if (ack !== want_ack) begin
                bad++;
                $display("FAIL b2b_ack cycle %0d: got %b want %b", j, ack, want_ack);
            end else if (ack === 1'b1) begin
                want = exp_q.pop_front();
                total++;
                if (dat_r !== want) begin
                    bad++;
                    $display("FAIL b2b_data cycle %0d: got %h want %h", j, dat_r, want);
                end
            end
        end
        stb = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_abort();
        test_inv();
        test_out_of_range();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/deja_glitch_power_mc.md
Name: deja_glitch_power_mc

Overview:
Multi-channel, parametrised successor to the single-channel power glitcher. Each channel cuts its power_o bit for a programmable width after a programmable delay from the rising edge of run_i. With sweep enabled, the delay auto-advances by a programmable step after every completed run, so repeated runs scan the glitch across a target window. Configured over the team's 8-bit strobe/ack register bus; sits between the host register block and the target-board power switches.

Parameters:
CHANNELS, 2, number of independent glitch channels (1..8)
CNT_W, 8, width of the delay/width/step counters; must equal DAT_W
DAT_W, 8, register data bus width
ADR_W, 5, register address width; must be >= clog2(CHANNELS)+2

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_ni  in  1  asynchronous active-low reset
stb_i  in  1  register access strobe
we_i  in  1  write enable (1 = write, 0 = read)
adr_i  in  ADR_W  address: {channel, reg[1:0]}
dat_i  in  DAT_W  write data
ack_o  out  1  access acknowledge
dat_o  out  DAT_W  read data, valid while ack_o = 1
run_i  in  1  test run gate; a rising edge starts all enabled channels
power_o  out  CHANNELS  per-channel power control; 1 = powered (normal polarity)

Behaviour:
- Reset (rst_ni low, async): every register 0, every FSM IDLE, ack_o = 0, dat_o = 0, power_o = all ones.
- Register map per channel ch, address ch*4 + r:
  - r0 DELAY: live delay; sweep modifies it in place.
  - r1 WIDTH.
  - r2 STEP.
  - r3 CTRL: bit0 EN, bit1 INV (invert power_o polarity), bit2 SWEEP, bit7 BUSY (read-only, FSM not IDLE). Bits 6:3 read as 0.
  - Access to a channel index >= CHANNELS: write ignored, read returns 0, still acked.
- Bus timing:
  - ack_o is asserted for exactly one cycle, in the cycle after stb_i is sampled high.
  - A held stb_i gets alternate-cycle acks: ack_o = stb_i & ~ack_o, registered.
  - A write commits on the same edge that raises ack_o.
- Run edge detection: rise = run_i & ~run_q, where run_q is run_i registered. rise is sampled at edge k.
- Per-channel FSM:
  - At run start (rise, EN = 1), DELAY, WIDTH and INV are latched into shadow registers. Mid-run writes affect only the next run.
  - IDLE -> DLY on rise when EN = 1.
  - DLY: counts the shadow delay. With shadow DELAY = D, power is cut from edge k+1+D through edge k+D+W, where W = shadow WIDTH.
  - DLY -> GLT when the count reaches D. D = 0 cuts power at the first cycle after k.
  - GLT -> HOLD after W cycles. W = 0 skips GLT and produces no cut.
  - HOLD -> IDLE when run_i is low.
  - On entering HOLD with SWEEP = 1: DELAY <= DELAY + STEP, modulo 2^CNT_W (wraps, no saturation).
- Abort: run_i low while in DLY or GLT -> IDLE next edge; power is restored that edge and no sweep increment occurs.
- Simultaneous bus write to DELAY and sweep increment on the same edge: the bus write wins.
- Clearing EN mid-run behaves as an abort.
- power_o[ch] = ~(state == GLT) ^ shadow_INV. In IDLE with INV set, the live CTRL.INV is used so polarity changes take effect immediately.
- Channels are fully independent; all share run_i.

Optional Feature:
DEJA_GLITCH_SYNC_EN
- Defined: run_i passes through a 2-flop synchroniser before edge detection, adding exactly 2 cycles to every run_i-relative timing (cut starts at edge k+3+D).
- Undefined: run_i is used directly; the caller guarantees it is synchronous to clk_i.

Decomposition:
- Shared package deja_glitch_pkg:
  - register offsets REG_DELAY = 0, REG_WIDTH = 1, REG_STEP = 2, REG_CTRL = 3
  - CTRL bit indices
  - channel state enum {IDLE, DLY, GLT, HOLD}
- Sub-module deja_glitch_channel: one FSM, shadows and sweep adder, instantiated CHANNELS times by generate.
- The top level holds only bus decode, read mux, ack and run edge/sync logic.

Test Plan:
- Reset, then read every register -> all 0, power_o = 2'b11.
- Ch0 DELAY = 3, WIDTH = 2, EN = 1; raise run_i at edge k -> power_o[0] low at edges k+4 and k+5 only; power_o[1] stays 1.
- Ch0 SWEEP = 1, STEP = 2, DELAY = 250; six full runs -> DELAY reads 252, 254, 0, 2, 4, 6; each cut shifts by the matching delay.
- DELAY = 10, WIDTH = 20; drop run_i during GLT -> power restored next edge, DELAY unchanged, BUSY = 0.
- Ch1 INV = 1, WIDTH = 0, run pulse -> power_o[1] held 0 throughout, no cut pulse; write DELAY mid-run -> next run uses the new value.
- Write to a channel-3 address with CHANNELS = 2 -> ack_o after 1 cycle, read returns 0, no state change.
